// File: rtl/rvx10_store_monitor.sv
// rvx10_store_monitor: logs core stores into a FIFO and judges test completion from a tohost write.
// Define RVX10_STORE_MON_WATCHDOG_EN to add a hang watchdog that times out after TIMEOUT store-free cycles.
module rvx10_store_monitor #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0064,
  parameter logic [31:0] PASS_VALUE  = 32'd25,
  parameter int          TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] result,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        overflow,
  output logic [15:0] store_count,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_code
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, PASS, FAIL, HANG} state_t;
  state_t state, state_n;
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0] cnt, cnt_n, rest;
  logic store, full, pop, push, wd_hit;
  assign store   = state == RUN && mem_we;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign pop     = log_valid && log_ready;
  assign push    = store && (!full || pop);
  assign rd_next = rd_ptr + AW'(pop);
  assign rest    = cnt - (AW+1)'(pop);
  assign cnt_n   = rest + (AW+1)'(push);
  assign log_valid = cnt != '0;
`ifdef RVX10_STORE_MON_WATCHDOG_EN
  logic [31:0] wd;
  always_ff @(posedge clk)
    if (!reset) wd <= '0;
    else if (store) wd <= '0;
    else if (state == RUN) wd <= wd + 32'd1;
  assign wd_hit = state == RUN && wd == 32'(TIMEOUT);
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == RUN)
      state_n = (store && addr == TOHOST_ADDR) ? (result == PASS_VALUE ? PASS : FAIL)
              : wd_hit ? HANG : RUN;
  end
  always_comb begin
    done = state != RUN;
    pass = state == PASS;
  end
  always_ff @(posedge clk)
    if (!reset) fail_code <= '0;
    else if (state == RUN && state_n == FAIL) fail_code <= result;
    else if (state == RUN && state_n == HANG) fail_code <= 32'hDEAD_0001;
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr] <= addr;
      mem_d[wr_ptr] <= result;
    end
  // Head is registered: an entry pushed into an otherwise-empty FIFO bypasses the array.
  always_ff @(posedge clk)
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      log_addr    <= '0;
      log_data    <= '0;
      overflow    <= 1'b0;
      store_count <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(push);
      cnt    <= cnt_n;
      if ((push || pop) && cnt_n != '0) begin
        log_addr <= rest == '0 ? addr : mem_a[rd_next];
        log_data <= rest == '0 ? result : mem_d[rd_next];
      end
      if (store && !push) overflow <= 1'b1;
      if (store && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
    end
endmodule
